// File: rtl/axil_cmd_master.sv
// AXI-Lite initiator: turns single register read/write commands into AXI-Lite
// transactions, one at a time, with a watchdog that aborts a stalled slave.
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  AXPROT         = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        hung,
    output logic [15:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [15:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic             cmd_ready_d, rsp_valid_d, rsp_timeout_d, hung_d;
    logic [31:0]      rsp_rdata_d, wdata_d;
    logic [1:0]       rsp_resp_d;
    logic [15:0]      awaddr_d, araddr_d;
    logic [3:0]       wstrb_d;
    logic             awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic             tmo, busy, at_limit;
    logic             aw_hs, w_hs;

    assign m_axi_awprot = AXPROT;
    assign m_axi_arprot = AXPROT;

    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign busy     = (state_q != IDLE) && (state_q != RSP);
    assign at_limit = (cnt_q == CNT_LIMIT);

    // State and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_timeout   <= 1'b0;
            hung          <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            hung          <= hung_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cmd_ready_d   = cmd_ready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        hung_d        = hung;
        awaddr_d      = m_axi_awaddr;
        awvalid_d     = m_axi_awvalid;
        wdata_d       = m_axi_wdata;
        wstrb_d       = m_axi_wstrb;
        wvalid_d      = m_axi_wvalid;
        bready_d      = m_axi_bready;
        araddr_d      = m_axi_araddr;
        arvalid_d     = m_axi_arvalid;
        rready_d      = m_axi_rready;
        tmo           = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else if (at_limit) begin
                    tmo = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi_bvalid && m_axi_bready) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RSP;
                end else if (at_limit) begin
                    tmo = 1'b1;
                end
            end
            RD_AR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end else if (at_limit) begin
                    tmo = 1'b1;
                end
            end
            RD_R: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    rready_d      = 1'b0;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RSP;
                end else if (at_limit) begin
                    tmo = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturating watchdog; never wraps back into a false "fresh" window
        if (busy && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Abort: release the bus and answer with SLVERR-style timeout
        if (tmo) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            hung_d        = 1'b1;
            state_d       = RSP;
        end
    end
endmodule
